// File: rtl/mem_bus_initiator_if.sv
// mem_bus_initiator_if: bundle of the core-side request/response handshakes and
// the memory-side port driven by the initiator.
//
// Handshake semantics (both request and response channels): a transfer happens
// at a rising clk edge where valid & ready are both high. The source holds valid
// and its payload stable until that edge; ready may change freely.
//
// Modports:
//   master - the initiator (drives req_ready, resp_*, mem_* outputs)
//   slave  - the environment (core + memory) facing the initiator
interface mem_bus_initiator_if #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int MAX_BEATS = 4
);
  localparam int CNT_W = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

  // core request channel
  logic                        req_valid;
  logic                        req_ready;
  logic [ADDR_W-1:0]           req_addr;
  logic                        req_we;
  logic                        req_acc_sz;
  logic [CNT_W-1:0]            req_burst_len;
  logic [DATA_W-1:0]           req_write_data;
  // core response channel
  logic                        resp_valid;
  logic                        resp_ready;
  logic [MAX_BEATS*DATA_W-1:0] resp_data;
  // memory port
  logic [ADDR_W-1:0]           mem_addr_out;
  logic [DATA_W-1:0]           mem_write_data_out;
  logic                        mem_data_acc_sz;
  logic                        mem_write_data_we;
  logic [DATA_W-1:0]           mem_read_data_in;

  modport master (
    input  req_valid, req_addr, req_we, req_acc_sz, req_burst_len, req_write_data,
    output req_ready,
    output resp_valid, resp_data,
    input  resp_ready,
    output mem_addr_out, mem_write_data_out, mem_data_acc_sz, mem_write_data_we,
    input  mem_read_data_in
  );

  modport slave (
    output req_valid, req_addr, req_we, req_acc_sz, req_burst_len, req_write_data,
    input  req_ready,
    input  resp_valid, resp_data,
    output resp_ready,
    input  mem_addr_out, mem_write_data_out, mem_data_acc_sz, mem_write_data_we,
    output mem_read_data_in
  );
endinterface

// File: rtl/mem_bus_initiator.sv
// mem_bus_initiator: bus-master end of the synchronous test-memory port.
// Accepts core requests, runs 1..MAX_BEATS beat read bursts or single-beat
// writes, overlaps address issue with the memory's one-cycle registered read
// latency, and returns the packed read data on a response handshake.
//
// Ports:
//   clk        - single clock shared with the memory responder
//   reset      - asynchronous, active-high
//   bus        - mem_bus_initiator_if.master (request, response, memory port)
//   dbg_state  - current FSM state, for observation only
module mem_bus_initiator #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int MAX_BEATS = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_bus_initiator_if.master  bus,
  output logic [2:0]           dbg_state
);
  localparam int CNT_W = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  localparam int RD_W  = MAX_BEATS * DATA_W;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_ISSUE = 3'd1,
    RD_DRAIN = 3'd2,
    WR       = 3'd3,
    RESP     = 3'd4
  } state_t;

  state_t              state_q,      state_d;
  logic [ADDR_W-1:0]   mem_addr_q,   mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q,  mem_wdata_d;
  logic                mem_acc_q,    mem_acc_d;
  logic                mem_we_q,     mem_we_d;
  logic                resp_valid_q, resp_valid_d;
  logic [RD_W-1:0]     resp_data_q,  resp_data_d;
  logic [CNT_W-1:0]    len_m1_q,     len_m1_d;
  logic [CNT_W-1:0]    issue_cnt_q,  issue_cnt_d;
  logic [CNT_W-1:0]    capt_cnt_q,   capt_cnt_d;

  logic [DATA_W-1:0]   capt_word;
  logic [ADDR_W-1:0]   stride;

  always_comb begin
    state_d      = state_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_acc_d    = mem_acc_q;
    mem_we_d     = 1'b0;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    len_m1_d     = len_m1_q;
    issue_cnt_d  = issue_cnt_q;
    capt_cnt_d   = capt_cnt_q;

    // Byte reads only keep the byte lane; the upper bits are zero-filled.
    capt_word = mem_acc_q ? bus.mem_read_data_in
                          : {{(DATA_W-8){1'b0}}, bus.mem_read_data_in[7:0]};
    stride    = mem_acc_q ? ADDR_W'(2) : ADDR_W'(1);

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          mem_addr_d  = bus.req_addr;
          mem_wdata_d = bus.req_write_data;
          mem_acc_d   = bus.req_acc_sz;
          if (bus.req_we) begin
            mem_we_d = 1'b1;
            state_d  = WR;
          end else begin
            len_m1_d    = bus.req_burst_len;
            issue_cnt_d = '0;
            capt_cnt_d  = '0;
            resp_data_d = '0;
            state_d     = RD_ISSUE;
          end
        end
      end
      RD_ISSUE: begin
        // issue_cnt is still 0 on the first edge in this state, when the
        // first address has not yet been sampled by the memory.
        if (issue_cnt_q != '0) begin
          resp_data_d[int'(capt_cnt_q)*DATA_W +: DATA_W] = capt_word;
          capt_cnt_d = capt_cnt_q + CNT_W'(1);
        end
        if (issue_cnt_q < len_m1_q) begin
          mem_addr_d  = mem_addr_q + stride;
          issue_cnt_d = issue_cnt_q + CNT_W'(1);
        end else begin
          state_d = RD_DRAIN;
        end
      end
      RD_DRAIN: begin
        // Data for the last address arrives one cycle after it was presented.
        resp_data_d[int'(capt_cnt_q)*DATA_W +: DATA_W] = capt_word;
        capt_cnt_d   = capt_cnt_q + CNT_W'(1);
        resp_valid_d = 1'b1;
        state_d      = RESP;
      end
      WR: begin
        resp_valid_d = 1'b1;
        resp_data_d  = '0;
        state_d      = RESP;
      end
      RESP: begin
        if (resp_valid_q && bus.resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_acc_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      len_m1_q     <= '0;
      issue_cnt_q  <= '0;
      capt_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_acc_q    <= mem_acc_d;
      mem_we_q     <= mem_we_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      len_m1_q     <= len_m1_d;
      issue_cnt_q  <= issue_cnt_d;
      capt_cnt_q   <= capt_cnt_d;
    end
  end

  assign bus.req_ready          = (state_q == IDLE);
  assign bus.resp_valid         = resp_valid_q;
  assign bus.resp_data          = resp_data_q;
  assign bus.mem_addr_out       = mem_addr_q;
  assign bus.mem_write_data_out = mem_wdata_q;
  assign bus.mem_data_acc_sz    = mem_acc_q;
  assign bus.mem_write_data_we  = mem_we_q;
  assign dbg_state              = state_q;
endmodule

// File: tb/tb_mem_bus_initiator.sv
module tb_mem_bus_initiator;
  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] dbg_state;

  mem_bus_initiator_if bus ();

  mem_bus_initiator dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.master),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- counters / check ----------------
  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- memory responder ----------------
  logic [15:0] mem [0:65535];
  logic [15:0] rd_q = 16'h0;
  assign bus.mem_read_data_in = rd_q;

  initial forever begin
    @(posedge clk);
    if (bus.mem_write_data_we === 1'b1) begin
      if (bus.mem_data_acc_sz) mem[bus.mem_addr_out] = bus.mem_write_data_out;
      else                     mem[bus.mem_addr_out][7:0] = bus.mem_write_data_out[7:0];
    end else begin
      rd_q <= mem[bus.mem_addr_out];
    end
  end

  // ---------------- behavioural model ----------------
  // m_k = index of the current cycle counted from the accepting edge (cycle 1
  // is the one right after it). Everything else is the latched request.
  bit          m_idle  = 1'b1;
  int          m_k     = 1;
  int          m_len   = 1;
  logic [15:0] m_addr  = 16'h0;
  logic [15:0] m_wdata = 16'h0;
  logic        m_acc   = 1'b0;
  logic        m_we    = 1'b0;
  logic [63:0] m_data  = 64'h0;
  logic [15:0] m_a, m_v;

  function automatic logic model_rv();
    return !m_idle && (m_k >= (m_we ? 2 : m_len + 2));
  endfunction

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      m_idle = 1'b1; m_k = 1; m_len = 1; m_addr = '0; m_wdata = '0;
      m_acc = 1'b0; m_we = 1'b0; m_data = '0;
    end else if (m_idle) begin
      if (bus.req_valid) begin
        m_idle  = 1'b0;
        m_k     = 1;
        m_addr  = bus.req_addr;
        m_acc   = bus.req_acc_sz;
        m_we    = bus.req_we;
        m_wdata = bus.req_write_data;
        m_len   = m_we ? 1 : int'(bus.req_burst_len) + 1;
        m_data  = '0;
        if (!m_we) begin
          for (int i = 0; i < m_len; i++) begin
            m_a = m_addr + 16'(i * (m_acc ? 2 : 1));
            m_v = mem[m_a];
            m_data[16*i +: 16] = m_acc ? m_v : {8'h00, m_v[7:0]};
          end
        end
      end
    end else if (model_rv() && bus.resp_ready) begin
      m_idle = 1'b1;
    end else begin
      m_k++;
    end
  end

  // ---------------- compare process ----------------
  int          c_j;
  logic [15:0] c_ea;

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      c_j  = ((m_k < m_len) ? m_k : m_len) - 1;
      c_ea = m_addr + 16'(c_j * (m_acc ? 2 : 1));
      check("req_ready",    64'(bus.req_ready),          64'(m_idle));
      check("mem_addr_out", 64'(bus.mem_addr_out),       64'(c_ea));
      check("mem_we",       64'(bus.mem_write_data_we),  64'(!m_idle && m_we && m_k == 1));
      check("mem_acc_sz",   64'(bus.mem_data_acc_sz),    64'(m_acc));
      check("mem_wdata",    64'(bus.mem_write_data_out), 64'(m_wdata));
      check("resp_valid",   64'(bus.resp_valid),         64'(model_rv()));
      if (model_rv()) check("resp_data", bus.resp_data, m_data);
    end
  end

  // ---------------- driver ----------------
  logic [15:0] tr [4];
  int          we_cnt;

  task automatic run_txn(input logic we, input logic acc, input logic [15:0] addr,
                         input logic [1:0] blen, input logic [15:0] wd, input int bp,
                         output logic [63:0] rdata, output int lat);
    int         guard;
    logic [2:0] st_hold;
    rdata = '0;
    lat   = 0;
    for (int i = 0; i < 4; i++) tr[i] = 16'hDEAD;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_acc_sz = acc; bus.req_addr = addr;
    bus.req_burst_len = blen; bus.req_write_data = wd; bus.resp_ready = 1'b0;
    guard = 0;
    while (bus.req_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("accept_wait", 64'(guard < 20), 64'd1);
    if (guard >= 20) begin
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    // Keep a second request pending through backpressure; it must be ignored.
    bus.req_valid = (bp > 0);
    we_cnt = 0;
    while (bus.resp_valid !== 1'b1 && lat < 12) begin
      if (lat < 4) tr[lat] = bus.mem_addr_out;
      if (bus.mem_write_data_we === 1'b1) we_cnt++;
      @(posedge clk); #1;
      lat++;
    end
    check("resp_wait", 64'(lat < 12), 64'd1);
    st_hold = dbg_state;
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      check("bp_state_hold", 64'(dbg_state), 64'(st_hold));
    end
    @(negedge clk);
    rdata = bus.resp_data;
    bus.resp_ready = 1'b1;
    bus.req_valid  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.resp_ready = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  logic [63:0] rd;
  int          lat;
  logic        r_we, r_acc;
  logic [1:0]  r_bl;
  logic [15:0] r_addr;

  initial begin
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_acc_sz = 1'b0; bus.req_addr = '0;
    bus.req_burst_len = '0; bus.req_write_data = '0; bus.resp_ready = 1'b0;
    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
    mem[16'h0010] = 16'hBEEF;
    mem[16'hFFFC] = 16'h1111; mem[16'hFFFE] = 16'h2222;
    mem[16'h0000] = 16'h3333; mem[16'h0002] = 16'h4444;
    mem[16'h0021] = 16'h55AA; mem[16'h0022] = 16'h66BB; mem[16'h0023] = 16'h77CC;

    #1 reset = 1'b1;
    #1 chk_en = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_req_ready",  64'(bus.req_ready),         64'd1);
    check("rst_resp_valid", 64'(bus.resp_valid),        64'd0);
    check("rst_mem_we",     64'(bus.mem_write_data_we), 64'd0);
    check("rst_mem_addr",   64'(bus.mem_addr_out),      64'd0);

    // 16-bit write, one we cycle, zero response data.
    run_txn(1'b1, 1'b1, 16'h0040, 2'd0, 16'hA55A, 0, rd, lat);
    check("wr_lat",    64'(lat),    64'd1);
    check("wr_data",   rd,          64'h0);
    check("wr_addr",   64'(tr[0]),  64'h0040);
    check("wr_we_cnt", 64'(we_cnt), 64'd1);

    // Asynchronous reset in the middle of a write cycle.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_acc_sz = 1'b1;
    bus.req_addr = 16'h0080; bus.req_write_data = 16'h1234;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    check("pre_rst_we", 64'(bus.mem_write_data_we), 64'd1);
    #1 reset = 1'b1;
    #1;
    check("arst_req_ready",  64'(bus.req_ready),          64'd1);
    check("arst_mem_we",     64'(bus.mem_write_data_we),  64'd0);
    check("arst_mem_addr",   64'(bus.mem_addr_out),       64'd0);
    check("arst_mem_wdata",  64'(bus.mem_write_data_out), 64'd0);
    check("arst_mem_acc",    64'(bus.mem_data_acc_sz),    64'd0);
    check("arst_resp_valid", 64'(bus.resp_valid),         64'd0);
    check("arst_resp_data",  bus.resp_data,               64'h0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Read back the earlier write.
    run_txn(1'b0, 1'b1, 16'h0040, 2'd0, 16'h0, 0, rd, lat);
    check("rb_data", rd, 64'h0000_0000_0000_A55A);

    // Single 16-bit read.
    run_txn(1'b0, 1'b1, 16'h0010, 2'd0, 16'h0, 0, rd, lat);
    check("r1_lat",  64'(lat),   64'd2);
    check("r1_addr", 64'(tr[0]), 64'h0010);
    check("r1_data", rd,         64'h0000_0000_0000_BEEF);

    // 4-beat 16-bit read across the address wrap.
    run_txn(1'b0, 1'b1, 16'hFFFC, 2'd3, 16'h0, 0, rd, lat);
    check("r4_lat",   64'(lat),   64'd5);
    check("r4_addr0", 64'(tr[0]), 64'hFFFC);
    check("r4_addr1", 64'(tr[1]), 64'hFFFE);
    check("r4_addr2", 64'(tr[2]), 64'h0000);
    check("r4_addr3", 64'(tr[3]), 64'h0002);
    check("r4_data",  rd,         64'h4444_3333_2222_1111);

    // 3-beat byte read.
    run_txn(1'b0, 1'b0, 16'h0021, 2'd2, 16'h0, 0, rd, lat);
    check("b3_lat",   64'(lat),   64'd4);
    check("b3_addr0", 64'(tr[0]), 64'h0021);
    check("b3_addr1", 64'(tr[1]), 64'h0022);
    check("b3_addr2", 64'(tr[2]), 64'h0023);
    check("b3_data",  rd,         64'h0000_00CC_00BB_00AA);

    // Backpressure with a competing request held high.
    run_txn(1'b0, 1'b1, 16'h0010, 2'd1, 16'h0, 3, rd, lat);
    check("bp_lat", 64'(lat), 64'd3);

    // Reset during the second beat of a 4-beat burst: no response ever.
    @(negedge clk);
    check("mb_ready", 64'(bus.req_ready), 64'd1);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_acc_sz = 1'b1;
    bus.req_addr = 16'h0100; bus.req_burst_len = 2'd3;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    check("mb_mem_we",     64'(bus.mem_write_data_we), 64'd0);
    check("mb_resp_valid", 64'(bus.resp_valid),        64'd0);
    check("mb_req_ready",  64'(bus.req_ready),         64'd1);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    bus.resp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("mb_no_resp", 64'(bus.resp_valid), 64'd0);
    end
    bus.resp_ready = 1'b0;

    // Randomized traffic against the model.
    for (int n = 0; n < 40; n++) begin
      r_we   = ($urandom_range(0, 3) == 0);
      r_acc  = 1'($urandom_range(0, 1));
      r_bl   = 2'($urandom_range(0, 3));
      r_addr = ($urandom_range(0, 3) == 0) ? 16'(16'hFFFF - 16'($urandom_range(0, 6)))
                                            : 16'($urandom);
      run_txn(r_we, r_acc, r_addr, r_bl, 16'($urandom), $urandom_range(0, 3), rd, lat);
      check("rand_lat", 64'(lat), r_we ? 64'd1 : 64'(int'(r_bl) + 2));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_bus_initiator.md
Name: mem_bus_initiator

Overview:
- Bus-master (initiator) end of the synchronous memory port used by the test memory: addr, write data, access size, write enable out; read data in.
- Accepts requests from the CPU core over a valid/ready handshake, sequences 1–4 beat read bursts or single-beat writes, and pipelines address issue against the memory's one-cycle registered read latency.
- Returns packed read data to the core over a valid/ready response handshake.

Parameters:
- ADDR_W, 16, address width; memory address arithmetic wraps modulo 2^ADDR_W.
- DATA_W, 16, memory data width; byte lane is bits [7:0].
- MAX_BEATS, 4, maximum read burst length; `resp_data` is MAX_BEATS*DATA_W wide.

Ports:
- clk  in  1  single clock; the memory responder shares it.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  core request valid.
- req_ready  out  1  high only in IDLE.
- req_addr  in  16  start address.
- req_we  in  1  1 = write, 0 = read.
- req_acc_sz  in  1  0 = 8-bit access, 1 = 16-bit access (cpu_data_acc_sz_8/_16).
- req_burst_len  in  2  beats minus 1 (0..3); ignored for writes.
- req_write_data  in  16  write data; byte writes use [7:0].
- resp_valid  out  1  response valid.
- resp_ready  in  1  core accepts the response.
- resp_data  out  64  beat i in [16i+15:16i]; unused slots are 0.
- mem_addr_out  out  16  to memory addr_in.
- mem_write_data_out  out  16  to memory write_data_in.
- mem_data_acc_sz  out  1  to memory data_acc_sz.
- mem_write_data_we  out  1  to memory write_data_we.
- mem_read_data_in  in  16  from memory read_data_out; valid the cycle after an address is presented with we=0.

Behaviour:
- Reset (async, immediate): state IDLE, all outputs 0 except req_ready=1. mem_write_data_we drops in the same instant, so there is never a partial or spurious write. Internal counters and capture slots are cleared.
- All memory-side outputs are registered.
- Stride is 1 for 8-bit accesses and 2 for 16-bit; the address wraps (0xFFFE+2 = 0x0000, 0xFFFF+1 = 0x0000).
- States are IDLE, RD_ISSUE, RD_DRAIN, WR, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid at edge E0, latch the request and load mem_addr_out, mem_data_acc_sz and mem_write_data_out.
  - On a write, set mem_write_data_we=1 and go to WR.
  - On a read, go to RD_ISSUE with issue_cnt=0, capt_cnt=0 and resp_data cleared.
  - mem_addr_out otherwise holds its last value; we=0.
- RD_ISSUE:
  - Each edge where issue_cnt < L-1 (L = burst_len+1): advance mem_addr_out by the stride and increment issue_cnt.
  - From the second cycle in the state, each edge also captures mem_read_data_in into slot capt_cnt and increments capt_cnt. Byte reads store {8'h00, data[7:0]}.
  - When the last address has been presented, go to RD_DRAIN.
- RD_DRAIN: one cycle. Capture the final beat, set resp_valid=1, go to RESP.
  - Read timing: address k is presented in cycle k+1 after E0. resp_valid rises at edge E(L+1) and is observed L+1 cycles after the accepting edge (L=1: 2 cycles; L=4: 5 cycles).
- WR: one cycle with we=1. At the next edge clear we, set resp_valid=1, set resp_data=0, go to RESP.
  - mem_write_data_we is high for exactly one cycle per write.
- RESP:
  - resp_valid and resp_data are held stable until resp_valid & resp_ready at an edge.
  - Then clear resp_valid and return to IDLE; a new request can be accepted no earlier than the following edge.
  - req_valid is ignored outside IDLE.
- The memory sees we=0 on every non-write cycle. Reads it performs while idle are harmless and are never captured.

Test Plan:
- Reset: assert reset mid-cycle -> all outputs 0 (req_ready 1) immediately, with no clock edge needed.
- Single 16-bit read at 0x0010, memory returns 16'hBEEF -> mem_addr_out=0x0010 one cycle; resp_valid 2 cycles after accept; resp_data=64'h0000_0000_0000_BEEF.
- 4-beat 16-bit read at 0xFFFC, memory returns 1111/2222/3333/4444 -> addresses FFFC, FFFE, 0000, 0002 on consecutive cycles; resp_valid 5 cycles after accept; resp_data=64'h4444_3333_2222_1111.
- 3-beat 8-bit read at 0x0021, bytes AA/BB/CC -> addresses 21, 22, 23; mem_data_acc_sz=0; resp_data=64'h0000_00CC_00BB_00AA.
- 16-bit write 0xA55A to 0x0040 -> we high exactly one cycle with addr 0x0040 and data 0xA55A; resp_valid next cycle with resp_data=0; a follow-up read of 0x0040 returns 0xA55A.
- Backpressure and reset: hold resp_ready=0 for 3 cycles with req_valid=1 -> resp_valid and resp_data stable, req_ready=0, the extra request is not accepted. Assert reset during the second beat of a burst -> we=0, resp_valid=0, IDLE, and no response ever issued.
